// File: rtl/rr_mux_reg.sv
// Registered N:1 selector with per-channel valid/ready and built-in arbitration.
// Supports round-robin or fixed-priority arbitration, with a one-cycle select-to-output latency.
module rr_mux_reg #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pri_mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  logic [SELW-1:0]     thresh;
  logic [SELW-1:0]     grant_idx;
  logic [WIDTH-1:0]    grant_data;
  logic [CHANNELS-1:0] grant;
  logic                found;
  logic                load;

  // Scan indices >= thresh first, then the wrapped-around indices below it.
  // A zero threshold turns this into a plain lowest-index priority encoder.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    found      = 1'b0;
    thresh     = pri_mode ? '0 : ptr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && in_valid[i] && (SELW'(i) >= thresh)) begin
        found      = 1'b1;
        grant[i]   = 1'b1;
        grant_idx  = SELW'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && in_valid[i] && (SELW'(i) < thresh)) begin
        found      = 1'b1;
        grant[i]   = 1'b1;
        grant_idx  = SELW'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (found) begin
        out_data_d  = grant_data;
        out_sel_d   = grant_idx;
        out_valid_d = 1'b1;
        if (!pri_mode) begin
          // Explicit wrap keeps ptr below CHANNELS for non-power-of-two counts.
          ptr_d = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised, registered N:1 data selector with per-channel valid/ready handshake and built-in arbitration (round-robin or fixed-priority). It replaces the fixed-width combinational selectors wherever several producers share one consumer, for example writeback sources or memory-request ports. The output is a registered stage with a one-cycle select-to-output latency and full one-transfer-per-cycle throughput.

## Interface
- WIDTH, 32, data width per channel (1..64)
- CHANNELS, 4, number of input channels (2..16)
- SELW, $clog2(CHANNELS), width of the channel-index output (derived; do not override)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  one clock; reset is synchronous and active-low
- pri_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled every cycle
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i presents data
- in_ready  output  CHANNELS  channel i's data is taken this cycle
- out_data  output  WIDTH  registered selected data
- out_sel  output  SELW  registered index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold an untaken item
- out_ready  input  1  consumer accepts the item this cycle

## Operation
- Reset (rst_n=0 at a rising edge): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is 0 while rst_n=0.
- load = ~out_valid | out_ready. This is the output register's free-or-draining condition.
- Arbitration is combinational over in_valid:
  - Round-robin: grant goes to the first asserted in_valid scanning ptr, ptr+1, ..., wrapping modulo CHANNELS.
  - Fixed priority: grant goes to the lowest asserted index. ptr is ignored.
- Exactly one grant bit or none (one-hot0). in_ready[i] = rst_n & load & grant[i].
- Transfer on channel i when in_valid[i] & in_ready[i]. On that edge:
  - out_data ← channel i data.
  - out_sel ← i.
  - out_valid ← 1.
  - In round-robin mode, ptr ← (i+1) mod CHANNELS. When CHANNELS is not a power of two, wrap explicitly; ptr never holds ≥ CHANNELS.
- In fixed-priority mode, ptr holds its value. Switching pri_mode never resets ptr.
- When load=1 and no in_valid is asserted: out_valid ← 0. out_data and out_sel hold their values, which are don't-care.
- When load=0: all outputs and ptr hold, and every in_ready bit is 0.
- Producers must hold in_valid and data stable until they are taken. in_valid must not depend on in_ready. in_ready may depend combinationally on in_valid and out_ready.
- Fairness: in round-robin mode with all channels continuously valid and out_ready=1, each channel is granted exactly once every CHANNELS transfers.

## Timing
- Latency: an input taken at edge k appears on out_data/out_valid after edge k; it is visible in cycle k+1.
- Throughput: one transfer per cycle while out_ready=1. This is a simultaneous drain and refill of the output register; no bubble is inserted.
- Backpressure: out_ready=0 with out_valid=1 stalls all inputs in the same cycle. There is no skid buffer, so the combinational path runs out_ready → in_ready.
- Reset mid-transfer: an item held in the output register is discarded, and out_valid is 0 in the cycle after the reset edge. Inputs asserted during reset are not taken.
- A simultaneous in_valid rise on several channels in the same cycle is resolved by the current mode in that same cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=4'b1111 → in_ready=0, out_valid=0, out_data=0, out_sel=0; after release, the first grant is channel 0.
- Round-robin fairness (CHANNELS=4, WIDTH=32): in_valid=4'b1111, channel i data = 0xA0+i, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 with matching data, and out_valid=1 continuously from cycle 1.
- Sparse round-robin: only channels 1 and 3 valid, ptr=2 → grant 3 first, then 1, then 3; ptr wraps 3→0 after granting 3.
- Fixed priority: pri_mode=1, in_valid=4'b1110 for 3 cycles → out_sel=1 on every transfer; channel 2 is never ready. On return to pri_mode=0, arbitration resumes from the ptr saved before the switch.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with all inputs valid → in_ready=0 throughout and out_data stable. When out_ready rises, the held item drains and the next item loads on the same edge.
- Mid-operation reset plus odd width (CHANNELS=3, WIDTH=5): in_valid=3'b111 streaming, assert rst_n=0 for 1 cycle → out_valid=0 the next cycle and ptr=0; the subsequent grant order is 0,1,2,0 (ptr wraps at 3).
